muldiv_hilo_unit: RTL and testbench
===================================

# muldiv_hilo_unit

Parametrised multi-cycle multiply/divide unit that owns the HI and LO special registers of the datapath. It generalises the fixed 32-bit HI/LO pair with a WIDTH parameter, sequential shift-add multiply, restoring divide, busy/done handshake and divide-by-zero reporting. It sits beside the ALU on the bus. Operands come from the bus/Y path. HI/LO drive the bus mux inputs used by mfhi/mflo, and mthi/mtlo load them directly from the bus.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  2  00 MUL (signed), 01 DIV (signed), 10 MULU, 11 DIVU.
- opa  in  WIDTH  multiplicand / dividend, sampled with start.
- opb  in  WIDTH  multiplier / divisor, sampled with start.
- bus_data  in  WIDTH  bus value for direct HI/LO loads.
- hi_in  in  1  load HI from bus_data (mthi).
- lo_in  in  1  load LO from bus_data (mtlo).
- hi_q  out  WIDTH  HI register (bus mux input).
- lo_q  out  WIDTH  LO register (bus mux input).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO just written by an operation.
- div_zero  out  1  last DIV/DIVU had divisor 0; held until the next accepted start.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - start=1 latches the operands and goes to RUN.
  - Signed ops convert operands to magnitudes and record result/remainder signs.
  - Iteration counter loads WIDTH-1.
- **RUN**: one iteration per cycle; after WIDTH iterations, go to FIX.
  - MUL: shift-add on magnitudes into a 2·WIDTH accumulator.
  - DIV: restoring division on magnitudes, one quotient bit per cycle.
- **FIX**
  - Apply sign correction, write HI/LO, pulse done, return to IDLE.
- **Multiply result**: HI = product[2W-1:W], LO = product[W-1:0], exact two's complement.
- **Divide result**: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - MIN/-1: LO = MIN, HI = 0. No exception is raised.
- **Divide by zero**
  - Iterations still run so latency is fixed.
  - FIX writes LO = all ones and HI = opa, and sets div_zero.
- hi_in/lo_in load in any state except FIX (loads are not blocked by busy).
  - A FIX write overwrites any earlier load, and wins over a load in the same cycle.
- start while busy is ignored: no queueing, no error.
- start together with hi_in/lo_in in IDLE: the load takes effect and the operation is accepted. The later FIX write replaces it.
- Reset (any time, including mid-RUN): state IDLE; hi_q = lo_q = 0; busy = done = div_zero = 0. The partial result is discarded.

## Timing
- start sampled at edge E0. Iterations happen at E1..E_WIDTH. FIX writes at E_(WIDTH+1).
- busy is high from after E0 until E_(WIDTH+1).
- done and the new hi_q/lo_q are visible after E_(WIDTH+1), for exactly one cycle of done.
- Latency from start to result: WIDTH+1 cycles (33 for WIDTH=32), identical for all ops and operands.
- A new start is accepted in the cycle done is high; back-to-back throughput is one op per WIDTH+2 cycles.
- hi_in/lo_in take effect at the next edge: one-cycle latency.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- MULDIV_UNSIGNED_EN defined: op 10/11 perform unsigned multiply/divide. Sign conversion and fixup are bypassed and operands are treated as WIDTH-bit unsigned.
- Not defined: the unsigned path is not built. op[1] is ignored, so 10 executes MUL and 11 executes DIV.

## Structure
- Package muldiv_pkg holds:
  - the op enum (MD_MUL, MD_DIV, MD_MULU, MD_DIVU);
  - the state enum (MD_IDLE, MD_RUN, MD_FIX);
  - a function for the counter width, $clog2(WIDTH).
- Sub-module hilo_regs: the HI/LO register pair.
  - Asynchronous active-low clear.
  - Load priority: FIX write > bus load.
  - Instantiated once; the FSM and iteration datapath live in the top module.

## Test plan
All scenarios use WIDTH=32.
- MUL 6 × 7 → after 33 cycles LO=0x0000002A, HI=0; done high for 1 cycle; busy low the next cycle.
- MUL -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. With MULDIV_UNSIGNED_EN, MULU 0xFFFFFFFF × 2 → HI=0x00000001, LO=0xFFFFFFFE.
- DIV 17 / -5 → LO=0xFFFFFFFD, HI=2. DIV -17 / 5 → LO=0xFFFFFFFD, HI=0xFFFFFFFE. DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIV 9 / 0 → LO=0xFFFFFFFF, HI=9, div_zero=1. div_zero stays high until the next start, then clears after E0.
- start pulsed again mid-RUN with different operands → ignored, the original result appears at cycle 33. lo_in with 0x1234 in IDLE → lo_q=0x1234 after one edge.
- clr asserted at iteration 10 → hi_q, lo_q, busy, done, div_zero = 0 immediately (asynchronously). A fresh MUL 2 × 3 after release gives LO=6.

Source files
------------

// File: rtl/muldiv_hilo_unit_pkg.sv
// muldiv_pkg: shared types for the HI/LO multiply/divide unit.
// Holds the operation and state encodings plus the iteration-counter width helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIV  = 2'b01,
        MD_MULU = 2'b10,
        MD_DIVU = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // Bits needed to hold the iteration count WIDTH-1 down to 0.
    function automatic int md_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Bus-side signal bundle of the multiply/divide unit: operation request,
// direct HI/LO loads, and the HI/LO/status outputs seen by the bus mux.
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] bus_data;
    logic             hi_in;
    logic             lo_in;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, opa, opb, bus_data, hi_in, lo_in,
        input  hi_q, lo_q, busy, done, div_zero
    );

    modport slave (
        input  start, op, opa, opb, bus_data, hi_in, lo_in,
        output hi_q, lo_q, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_hilo_unit_hilo_regs.sv
// hilo_regs: the HI/LO special register pair.
// An operation result write always beats a direct bus load in the same cycle.
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             fix_we,
    input  logic [WIDTH-1:0] fix_hi,
    input  logic [WIDTH-1:0] fix_lo,
    input  logic             hi_ld,
    input  logic             lo_ld,
    input  logic [WIDTH-1:0] bus_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // Next HI/LO: result write first, otherwise individual bus loads.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (fix_we) begin
            hi_d = fix_hi;
            lo_d = fix_lo;
        end else begin
            if (hi_ld) hi_d = bus_data;
            if (lo_ld) lo_d = bus_data;
        end
    end

    // HI/LO storage, cleared asynchronously.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: multi-cycle multiply/divide owning HI/LO.
// Shift-add multiply and restoring divide on magnitudes, WIDTH iterations,
// then one fixup cycle that applies signs and writes HI/LO.
// Optional feature macro: MULDIV_UNSIGNED_EN (builds the MULU/DIVU path;
// without it op[1] is ignored and the signed ops run).
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               clr,
    muldiv_hilo_unit_if.slave bus
);
    localparam int CNT_W = md_cnt_w(WIDTH);
    localparam logic [1:0] S_IDLE = MD_IDLE;
    localparam logic [1:0] S_RUN  = MD_RUN;
    localparam logic [1:0] S_FIX  = MD_FIX;

    // Shift-add step: add multiplicand on LSB, shift the 2W accumulator right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0] mc);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // Restoring step: {remainder, dividend/quotient} shifts left one bit.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, dv};
        if (shifted >= {1'b0, dv}) return {WIDTH'(trial), acc[WIDTH-2:0], 1'b1};
        else                       return {WIDTH'(shifted), acc[WIDTH-2:0], 1'b0};
    endfunction

    // Conditional two's-complement negation of a WIDTH value.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Conditional two's-complement negation of the 2W product.
    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic               is_div_q, is_div_d;
    logic               b_zero_q, b_zero_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    md_op_e                  op_e;
    logic                    op_signed;
    logic signed [WIDTH-1:0] opa_s;
    logic signed [WIDTH-1:0] opb_s;
    logic                    a_neg;
    logic                    b_neg;
    logic                    accept;
    logic                    fix_we;
    logic [WIDTH-1:0]        fix_hi;
    logic [WIDTH-1:0]        fix_lo;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        hi_reg;
    logic [WIDTH-1:0]        lo_reg;

    assign op_e  = md_op_e'(bus.op);
    assign opa_s = bus.opa;
    assign opb_s = bus.opb;
`ifdef MULDIV_UNSIGNED_EN
    assign op_signed = (op_e == MD_MUL) || (op_e == MD_DIV);
`else
    assign op_signed = 1'b1;
`endif
    assign a_neg  = op_signed && (opa_s < 0);
    assign b_neg  = op_signed && (opb_s < 0);
    assign accept = (state_q == S_IDLE) && bus.start;

    // Control FSM: accept in IDLE, count WIDTH iterations, one fixup cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        fix_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                fix_we  = 1'b1;
                if (is_div_q && b_zero_q) div_zero_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Iteration datapath: latch magnitudes/signs on accept, step while running.
    always_comb begin
        acc_d     = acc_q;
        mag_b_d   = mag_b_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        b_zero_d  = b_zero_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            acc_d     = {{WIDTH{1'b0}}, cond_neg(bus.opa, a_neg)};
            mag_b_d   = cond_neg(bus.opb, b_neg);
            opa_d     = bus.opa;
            is_div_d  = (op_e == MD_DIV) || (op_e == MD_DIVU);
            b_zero_d  = (bus.opb == '0);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
        end else if (state_q == S_RUN) begin
            acc_d = is_div_q ? div_step(acc_q, mag_b_q) : mul_step(acc_q, mag_b_q);
        end
    end

    // Result fixup: sign correction and the divide-by-zero substitute values.
    always_comb begin
        prod   = cond_neg2(acc_q, neg_res_q);
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                fix_hi = opa_q;
                fix_lo = '1;
            end else begin
                fix_hi = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                fix_lo = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
            end
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Datapath registers; always reloaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        mag_b_q   <= mag_b_d;
        opa_q     <= opa_d;
        is_div_q  <= is_div_d;
        b_zero_q  <= b_zero_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
    end

    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk      (clk),
        .clr      (clr),
        .fix_we   (fix_we),
        .fix_hi   (fix_hi),
        .fix_lo   (fix_lo),
        .hi_ld    (bus.hi_in),
        .lo_ld    (bus.lo_in),
        .bus_data (bus.bus_data),
        .hi_q     (hi_reg),
        .lo_q     (lo_reg)
    );

    assign bus.hi_q     = hi_reg;
    assign bus.lo_q     = lo_reg;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit at WIDTH=32: multiply/divide results,
// fixed latency, div-by-zero flag, ignored start, bus loads, async clear.
module tb_muldiv_hilo_unit;
    localparam int W = 32;

    logic clk;
    logic clr;
    int   total = 0;
    int   bad   = 0;
    int   lat;
    logic b0;
    logic dz0;

    muldiv_hilo_unit_if #(.WIDTH(W)) bus_if ();

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; returns edges from E0 to done, plus busy/div_zero after E0.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic busy0, output logic dzero0);
        bus_if.op    = op;
        bus_if.opa   = a;
        bus_if.opb   = b;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        busy0  = bus_if.busy;
        dzero0 = bus_if.div_zero;
        n = 0;
        while (!bus_if.done && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        bus_if.start    = 1'b0;
        bus_if.op       = 2'b00;
        bus_if.opa      = '0;
        bus_if.opb      = '0;
        bus_if.bus_data = '0;
        bus_if.hi_in    = 1'b0;
        bus_if.lo_in    = 1'b0;
        clr = 1'b1;
        #1 clr = 1'b0;
        #12;
        chk("rst_hi", bus_if.hi_q, 32'h0);
        chk("rst_lo", bus_if.lo_q, 32'h0);
        chk("rst_busy", {31'b0, bus_if.busy}, 32'h0);
        chk("rst_done", {31'b0, bus_if.done}, 32'h0);
        chk("rst_dz", {31'b0, bus_if.div_zero}, 32'h0);
        clr = 1'b1;
        tick();

        // direct loads, one-edge latency
        bus_if.bus_data = 32'h1234;
        bus_if.lo_in    = 1'b1;
        tick();
        bus_if.lo_in = 1'b0;
        chk("mtlo_lo", bus_if.lo_q, 32'h1234);
        chk("mtlo_hi", bus_if.hi_q, 32'h0);
        bus_if.bus_data = 32'hABCD;
        bus_if.hi_in    = 1'b1;
        tick();
        bus_if.hi_in = 1'b0;
        chk("mthi_hi", bus_if.hi_q, 32'hABCD);

        // MUL 6 x 7
        run_op(2'b00, 32'd6, 32'd7, lat, b0, dz0);
        chk("mul67_busy0", {31'b0, b0}, 32'h1);
        chk("mul67_lat", lat, 33);
        chk("mul67_lo", bus_if.lo_q, 32'h0000002A);
        chk("mul67_hi", bus_if.hi_q, 32'h0);
        tick();
        chk("mul67_done_pulse", {31'b0, bus_if.done}, 32'h0);
        chk("mul67_busy_after", {31'b0, bus_if.busy}, 32'h0);

        // MUL -3 x 5
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, b0, dz0);
        chk("mulneg_lat", lat, 33);
        chk("mulneg_hi", bus_if.hi_q, 32'hFFFFFFFF);
        chk("mulneg_lo", bus_if.lo_q, 32'hFFFFFFF1);

        // op 10: MULU when built, otherwise executes signed MUL (-1 x 2)
        run_op(2'b10, 32'hFFFFFFFF, 32'd2, lat, b0, dz0);
`ifdef MULDIV_UNSIGNED_EN
        chk("mulu_hi", bus_if.hi_q, 32'h00000001);
`else
        chk("op10_hi", bus_if.hi_q, 32'hFFFFFFFF);
`endif
        chk("op10_lo", bus_if.lo_q, 32'hFFFFFFFE);

        // signed divides
        run_op(2'b01, 32'd17, 32'hFFFFFFFB, lat, b0, dz0);
        chk("div1_lat", lat, 33);
        chk("div1_lo", bus_if.lo_q, 32'hFFFFFFFD);
        chk("div1_hi", bus_if.hi_q, 32'h2);
        run_op(2'b01, 32'hFFFFFFEF, 32'd5, lat, b0, dz0);
        chk("div2_lo", bus_if.lo_q, 32'hFFFFFFFD);
        chk("div2_hi", bus_if.hi_q, 32'hFFFFFFFE);
        run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, lat, b0, dz0);
        chk("divmin_lo", bus_if.lo_q, 32'h80000000);
        chk("divmin_hi", bus_if.hi_q, 32'h0);
        chk("divmin_dz", {31'b0, bus_if.div_zero}, 32'h0);

        // divide by zero
        run_op(2'b01, 32'd9, 32'd0, lat, b0, dz0);
        chk("dz_lat", lat, 33);
        chk("dz_lo", bus_if.lo_q, 32'hFFFFFFFF);
        chk("dz_hi", bus_if.hi_q, 32'd9);
        chk("dz_flag", {31'b0, bus_if.div_zero}, 32'h1);
        tick();
        tick();
        chk("dz_hold", {31'b0, bus_if.div_zero}, 32'h1);

        // start ignored mid-RUN, bus load during busy, div_zero clears at E0
        bus_if.op    = 2'b00;
        bus_if.opa   = 32'd6;
        bus_if.opb   = 32'd7;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        chk("dz_clear_e0", {31'b0, bus_if.div_zero}, 32'h0);
        lat = 0;
        repeat (5) begin
            tick();
            lat++;
        end
        bus_if.op       = 2'b01;
        bus_if.opa      = 32'd100;
        bus_if.opb      = 32'd3;
        bus_if.start    = 1'b1;
        bus_if.bus_data = 32'h55;
        bus_if.hi_in    = 1'b1;
        tick();
        lat++;
        bus_if.start = 1'b0;
        bus_if.hi_in = 1'b0;
        chk("busy_mthi", bus_if.hi_q, 32'h55);
        while (!bus_if.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 33);
        chk("ign_lo", bus_if.lo_q, 32'h0000002A);
        chk("ign_hi", bus_if.hi_q, 32'h0);
        tick();
        chk("ign_idle", {31'b0, bus_if.busy}, 32'h0);

        // asynchronous clear at iteration 10
        bus_if.op    = 2'b00;
        bus_if.opa   = 32'd6;
        bus_if.opb   = 32'd7;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (10) tick();
        #2 clr = 1'b0;
        #1;
        chk("clr_hi", bus_if.hi_q, 32'h0);
        chk("clr_lo", bus_if.lo_q, 32'h0);
        chk("clr_busy", {31'b0, bus_if.busy}, 32'h0);
        chk("clr_done", {31'b0, bus_if.done}, 32'h0);
        chk("clr_dz", {31'b0, bus_if.div_zero}, 32'h0);
        #2 clr = 1'b1;
        repeat (3) tick();
        chk("clr_stays_idle", {31'b0, bus_if.busy}, 32'h0);
        run_op(2'b00, 32'd2, 32'd3, lat, b0, dz0);
        chk("post_clr_lat", lat, 33);
        chk("post_clr_lo", bus_if.lo_q, 32'd6);
        chk("post_clr_hi", bus_if.hi_q, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
